// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-ported unified instruction/data memory of the multi-cycle
// processor between the CPU datapath and a debug/loader port. The CPU path is
// a zero-latency pass-through. Whenever the debug side owns the memory, the
// CPU is frozen through cpu_stall. The debug side can hold the memory across
// several transfers by keeping dbg_lock high (a locked burst).
//
// Optional feature, enabled by defining MEMARB_STARVE_GUARD_EN:
//   A starvation guard counts the arbitration cycles that a pending debug
//   request loses. After DBG_MAX_WAIT such cycles, the next cycle is given to
//   the debug port. Without the macro the CPU has strict priority in ARB mode,
//   and the debug port can starve.
//
// Parameters
//   ADDR_W        address width of both ports and the memory
//   DATA_W        data width
//   DBG_MAX_WAIT  lost cycles before a pending debug request is forced through
//
// Ports
//   clk, reset                   clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata        CPU access request for this cycle
//   cpu_rdata, cpu_stall         read data back to the CPU, CPU freeze
//   dbg_valid/we/lock/addr/wdata debug request; lock keeps the grant
//   dbg_ready                    debug request accepted this cycle
//   dbg_rvalid, dbg_rdata        registered debug read response (cycle N+1)
//   mem_addr/wdata/read/write    memory array control
//   mem_rdata                    combinational memory read data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DBG_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,

  input  logic              dbg_valid,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    ARB  = 1'b0,  // normal arbitration
    LOCK = 1'b1   // debug owns the memory, CPU frozen
  } mode_e;

  mode_e             mode_q, mode_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic              force_dbg;
  logic              dbg_grant;
  logic              cpu_grant;
  logic              dbg_xfer;

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(DBG_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(DBG_MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // The debug side is forced through once it has lost DBG_MAX_WAIT cycles.
  assign force_dbg = (wait_cnt_q == WAIT_MAX);
`else
  assign force_dbg = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Grant and memory mux (combinational, evaluated every cycle)
  // ---------------------------------------------------------------------------
  always_comb begin
    dbg_grant = 1'b0;
    cpu_grant = 1'b0;
    if (mode_q == LOCK) begin
      // The locked debug owner keeps the memory; the CPU is never granted,
      // even on idle gap cycles inside the burst.
      dbg_grant = dbg_valid;
      cpu_grant = 1'b0;
    end else begin
      dbg_grant = dbg_valid & (~cpu_req | force_dbg);
      cpu_grant = cpu_req & ~dbg_grant;
    end
  end

  assign dbg_xfer = dbg_valid & dbg_grant;

  always_comb begin
    // With no grant, the address idles on the CPU address.
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (dbg_grant) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_read  = ~dbg_we;
      // The memory commits on the next edge. Gating with reset keeps a write
      // that is in flight while reset is held from landing in the array.
      mem_write = dbg_we & reset;
    end else if (cpu_grant) begin
      mem_read  = ~cpu_we;
      mem_write = cpu_we & reset;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = (cpu_req & ~cpu_grant) | (mode_q == LOCK);
  assign dbg_ready  = dbg_grant;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_d       = mode_q;
    dbg_rvalid_d = dbg_xfer & ~dbg_we;
    dbg_rdata_d  = dbg_rdata_q;

    // The read response is captured at the accept edge. It is held afterwards
    // so dbg_rdata stays stable after the one-cycle rvalid pulse.
    if (dbg_xfer && !dbg_we) begin
      dbg_rdata_d = mem_rdata;
    end

    unique case (mode_q)
      ARB: begin
        if (dbg_xfer && dbg_lock) begin
          mode_d = LOCK;
        end
      end
      LOCK: begin
        // Dropping dbg_lock releases the memory at this edge, with or without
        // a final transfer in the same cycle.
        if (!dbg_lock) begin
          mode_d = ARB;
        end
      end
      default: mode_d = ARB;
    endcase
  end

`ifdef MEMARB_STARVE_GUARD_EN
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dbg_valid || dbg_xfer) begin
      wait_cnt_d = '0;
    end else if (mode_q == ARB && wait_cnt_q != WAIT_MAX) begin
      // Here dbg_valid is high and no transfer happened, so the request lost
      // this cycle to the CPU.
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q       <= ARB;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
`ifdef MEMARB_STARVE_GUARD_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      mode_q       <= mode_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
`ifdef MEMARB_STARVE_GUARD_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. It includes a small memory model:
// - Address 0x10 is a fixed ROM word (0xDEADBEEF).
// - Other addresses form a writable array indexed by mem_addr[7:0].
// Inputs change 1 time unit after each rising edge. Outputs are sampled
// 3 units after the edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dbg_valid, dbg_we, dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ready, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_read, mem_write;

  logic [DW-1:0] mem [0:255];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr[7:0] == 8'h10) ? 32'hDEAD_BEEF : mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
  end

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DBG_MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic set_dbg(input logic valid, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
    dbg_valid = valid; dbg_we = we; dbg_lock = lock; dbg_addr = addr; dbg_wdata = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    #2;
    chk("rst_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("rst_rdata", dbg_rdata, 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_ready", 32'(dbg_ready), 32'd0);
    chk("rst_memrd", 32'(mem_read), 32'd0);
    #10 reset = 1'b1;

    // CPU read at 0x10
    next_cycle();
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    settle();
    chk("cpu_rd_data", cpu_rdata, 32'hDEAD_BEEF);
    chk("cpu_rd_stall", 32'(cpu_stall), 32'd0);
    chk("cpu_rd_memrd", 32'(mem_read), 32'd1);
    chk("cpu_rd_addr", mem_addr, 32'h10);
    chk("cpu_rd_rvalid", 32'(dbg_rvalid), 32'd0);

    // Idle CPU, debug write 0x12345678 to 0x40
    next_cycle();
    set_cpu(1'b0, 1'b0, 32'h10, 32'h0);
    set_dbg(1'b1, 1'b1, 1'b0, 32'h40, 32'h1234_5678);
    settle();
    chk("dbg_wr_ready", 32'(dbg_ready), 32'd1);
    chk("dbg_wr_memwr", 32'(mem_write), 32'd1);
    chk("dbg_wr_addr", mem_addr, 32'h40);
    chk("dbg_wr_wdata", mem_wdata, 32'h1234_5678);
    chk("dbg_wr_stall", 32'(cpu_stall), 32'd0);

    // Debug read of 0x40, response one cycle later
    next_cycle();
    set_dbg(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    settle();
    chk("dbg_rd_ready", 32'(dbg_ready), 32'd1);
    chk("dbg_rd_memrd", 32'(mem_read), 32'd1);
    chk("dbg_rd_rvalid0", 32'(dbg_rvalid), 32'd0);
    next_cycle();
    set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("dbg_rd_rvalid1", 32'(dbg_rvalid), 32'd1);
    chk("dbg_rd_data", dbg_rdata, 32'h1234_5678);
    next_cycle();
    settle();
    chk("dbg_rd_rvalid2", 32'(dbg_rvalid), 32'd0);

    // Back-to-back reads: 0x10, then 0x40
    next_cycle();
    set_dbg(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    next_cycle();
    set_dbg(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    settle();
    chk("b2b_rvalid_a", 32'(dbg_rvalid), 32'd1);
    chk("b2b_data_a", dbg_rdata, 32'hDEAD_BEEF);
    next_cycle();
    set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("b2b_rvalid_b", 32'(dbg_rvalid), 32'd1);
    chk("b2b_data_b", dbg_rdata, 32'h1234_5678);

    // Continuous contention for 20 cycles
    next_cycle();
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    set_dbg(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 20; i++) begin
      logic exp_rdy;
`ifdef MEMARB_STARVE_GUARD_EN
      exp_rdy = ((i % (MAXW + 1)) == MAXW);
`else
      exp_rdy = 1'b0;
`endif
      settle();
      chk($sformatf("cont_ready_%0d", i), 32'(dbg_ready), 32'(exp_rdy));
      chk($sformatf("cont_stall_%0d", i), 32'(cpu_stall), 32'(exp_rdy));
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, 32'h10, 32'h0);
    set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Locked burst: 4 locked writes, 2-cycle gap, final unlocked write
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      set_dbg(1'b1, 1'b1, 1'b1, 32'h80 + 32'(i), 32'hA000_0000 + 32'(i));
      settle();
      chk($sformatf("lock_ready_%0d", i), 32'(dbg_ready), 32'd1);
      chk($sformatf("lock_memwr_%0d", i), 32'(mem_write), 32'd1);
      chk($sformatf("lock_addr_%0d", i), mem_addr, 32'h80 + 32'(i));
      // The CPU starts requesting once the burst holds the lock.
      if (i > 0) chk($sformatf("lock_stall_%0d", i), 32'(cpu_stall), 32'd1);
      next_cycle();
      set_cpu(1'b1, 1'b0, 32'h84, 32'h0);
    end
    for (int i = 0; i < 2; i++) begin
      set_dbg(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      settle();
      chk($sformatf("gap_stall_%0d", i), 32'(cpu_stall), 32'd1);
      chk($sformatf("gap_memrd_%0d", i), 32'(mem_read), 32'd0);
      next_cycle();
    end
    set_dbg(1'b1, 1'b1, 1'b0, 32'h84, 32'hA000_0004);
    settle();
    chk("final_ready", 32'(dbg_ready), 32'd1);
    chk("final_stall", 32'(cpu_stall), 32'd1);
    chk("final_memwr", 32'(mem_write), 32'd1);
    next_cycle();
    set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("post_stall", 32'(cpu_stall), 32'd0);
    chk("post_memrd", 32'(mem_read), 32'd1);
    chk("post_rdata", cpu_rdata, 32'hA000_0004);

    // Reset asserted while in LOCK with a pending read
    next_cycle();
    set_cpu(1'b0, 1'b0, 32'h10, 32'h0);
    set_dbg(1'b1, 1'b1, 1'b1, 32'h90, 32'h5555_AAAA);
    next_cycle();
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    set_dbg(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
    settle();
    chk("lk_stall", 32'(cpu_stall), 32'd1);
    chk("lk_ready", 32'(dbg_ready), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rstlk_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("rstlk_stall", 32'(cpu_stall), 32'd0);
    chk("rstlk_ready", 32'(dbg_ready), 32'd0);
    chk("rstlk_addr", mem_addr, 32'h10);
    next_cycle();
    settle();
    chk("rstlk_rvalid_edge", 32'(dbg_rvalid), 32'd0);
    set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    next_cycle();
    settle();
    chk("rel_stall", 32'(cpu_stall), 32'd0);
    chk("rel_memrd", 32'(mem_read), 32'd1);
    chk("rel_rdata", cpu_rdata, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
